write_resp_scheduler: RTL

Scheduler that shares one slave write channel among `NUM_M` masters and keeps the write-response path ordered. It round-robin arbitrates AW requests and pushes each granted master's ID into the response queue. It then routes every slave B response to the master at the queue head and pops the queue on the B handshake. It sits between the master-side AW/B ports and the slave-side port of the interconnect, and is the only agent that drives the response queue.

---
 rtl/write_resp_scheduler_if.sv | 47 ++++
 rtl/write_resp_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/write_resp_scheduler_if.sv
// Bundle of master-side AW/B, slave-side AW/B and response-queue signals
// around the write response scheduler.
interface write_resp_scheduler_if #(
    parameter int NUM_M   = 2,
    parameter int ID_W    = 1,
    parameter int Q_DEPTH = 4
) ();
    localparam int OW = $clog2(Q_DEPTH + 1);

    logic [NUM_M-1:0] m_awvalid;
    logic [NUM_M-1:0] m_awready;
    logic [ID_W-1:0]  aw_sel;
    logic             s_awvalid;
    logic             s_awready;
    logic [ID_W-1:0]  Master_ID;
    logic             Write_Resp_Grant;
    logic             Write_Resp_Finsh;
    logic [ID_W-1:0]  Resp_Master_ID;
    logic             Resp_Master_Valid;
    logic             Queue_Is_Full;
    logic             s_bvalid;
    logic [1:0]       s_bresp;
    logic             s_bready;
    logic [NUM_M-1:0] m_bvalid;
    logic [1:0]       m_bresp;
    logic [NUM_M-1:0] m_bready;
    logic [OW-1:0]    outstanding;
    logic             err_orphan_b;

    // Scheduler side.
    modport slave (
        input  m_awvalid, s_awready, Resp_Master_ID, Resp_Master_Valid,
        input  Queue_Is_Full, s_bvalid, s_bresp, m_bready,
        output m_awready, aw_sel, s_awvalid, Master_ID, Write_Resp_Grant,
        output Write_Resp_Finsh, s_bready, m_bvalid, m_bresp, outstanding,
        output err_orphan_b
    );

    // Environment side: masters, slave and response queue.
    modport master (
        output m_awvalid, s_awready, Resp_Master_ID, Resp_Master_Valid,
        output Queue_Is_Full, s_bvalid, s_bresp, m_bready,
        input  m_awready, aw_sel, s_awvalid, Master_ID, Write_Resp_Grant,
        input  Write_Resp_Finsh, s_bready, m_bvalid, m_bresp, outstanding,
        input  err_orphan_b
    );
endinterface

// File: rtl/write_resp_scheduler.sv
// Round-robin AW arbiter that pushes granted master IDs into the response
// queue and steers slave B responses to the master at the queue head.
module write_resp_scheduler #(
    parameter int NUM_M   = 2,
    parameter int ID_W    = 1,
    parameter int Q_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    write_resp_scheduler_if.slave bus
);
    localparam int OW = $clog2(Q_DEPTH + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic            err_orphan_q, err_orphan_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [NUM_M-1:0] m_awready;
    logic [ID_W-1:0]  aw_sel;
    logic             s_awvalid;
    logic [ID_W-1:0]  master_id;
    logic             push;
    logic             pop;
    logic             s_bready;
    logic [NUM_M-1:0] m_bvalid;

    // First requester at or after rr_ptr, wrapping past the last master.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_M;
            if (!pick_found && bus.m_awvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        s_awvalid = 1'b0;
        aw_sel    = '0;
        m_awready = '0;
        master_id = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !bus.Queue_Is_Full) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                s_awvalid          = 1'b1;
                aw_sel             = grant_q;
                m_awready[grant_q] = bus.s_awready;
                if (bus.s_awready) begin
                    push      = 1'b1;
                    master_id = grant_q;
                    rr_ptr_d  = (grant_q == ID_W'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B path is purely combinational; the queue head decides the target.
    assign s_bready = bus.Resp_Master_Valid & bus.m_bready[bus.Resp_Master_ID];
    assign pop      = bus.s_bvalid & s_bready;

    for (genvar i = 0; i < NUM_M; i++) begin : g_bvalid
        assign m_bvalid[i] = bus.s_bvalid & bus.Resp_Master_Valid &
                             (bus.Resp_Master_ID == ID_W'(i));
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({push, pop})
            2'b10: if (outstanding_q != OW'(Q_DEPTH)) outstanding_d = outstanding_q + 1'b1;
            2'b01: if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        err_orphan_d = err_orphan_q | (bus.s_bvalid & ~bus.Resp_Master_Valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    assign bus.m_awready        = m_awready;
    assign bus.aw_sel           = aw_sel;
    assign bus.s_awvalid        = s_awvalid;
    assign bus.Master_ID        = master_id;
    assign bus.Write_Resp_Grant = push;
    assign bus.Write_Resp_Finsh = pop;
    assign bus.s_bready         = s_bready;
    assign bus.m_bvalid         = m_bvalid;
    assign bus.m_bresp          = bus.s_bresp;
    assign bus.outstanding      = outstanding_q;
    assign bus.err_orphan_b     = err_orphan_q;
endmodule
